// File: rtl/csr_pkg.sv
// Shared types and constants for the CSR access controller: funct3 encodings,
// FSM states, the SYSTEM opcode and small instruction-decode helpers.
package csr_pkg;

    localparam logic [6:0] SYSTEM_OPCODE = 7'b1110011;

    typedef enum logic [2:0] {
        CSRRW  = 3'b001,
        CSRRS  = 3'b010,
        CSRRC  = 3'b011,
        CSRRWI = 3'b101,
        CSRRSI = 3'b110,
        CSRRCI = 3'b111
    } csr_funct3_e;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } csr_state_e;

    // 000 and 100 are not CSR operations.
    function automatic logic funct3_illegal(input logic [2:0] funct3);
        return funct3[1:0] == 2'b00;
    endfunction

    // RW/RWI always write.
    function automatic logic funct3_is_rw(input logic [2:0] funct3);
        return funct3[1:0] == 2'b01;
    endfunction

endpackage

// File: rtl/csr_alu.sv
// Combinational new-value computation for CSR read-modify-write operations.
module csr_alu
    import csr_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] old_val,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN-1:0] new_val
);

    // NOTE: give every combinational output a default first so no path leaves it unassigned (no latch).
    always_comb begin
        new_val = operand;
        case (funct3)
            CSRRS, CSRRSI: new_val = old_val | operand;
            CSRRC, CSRRCI: new_val = old_val & ~operand;
            default:       new_val = operand;
        endcase
    end

endmodule

// File: rtl/csr_access_ctrl.sv
// CSR access controller: sequences a SYSTEM CSR instruction through read,
// optional write and a held response, flagging illegal encodings.
module csr_access_ctrl
    import csr_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs1_data,
    output logic [11:0]     csr_addr,
    output logic            csr_we,
    output logic [XLEN-1:0] csr_wd,
    input  logic [XLEN-1:0] csr_rd,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [4:0]      resp_rd_addr,
    output logic [XLEN-1:0] resp_data,
    output logic            resp_illegal,
    output logic            busy
);

    csr_state_e      state, next_state;
    logic [11:0]     addr_q;
    logic [2:0]      funct3_q;
    logic [4:0]      rd_q;
    logic [4:0]      rs1_idx_q;
    logic [XLEN-1:0] rs1_data_q;
    logic [XLEN-1:0] zimm_q;
    logic [XLEN-1:0] old_q;
    logic [XLEN-1:0] new_q;
    logic            illegal_q;

    logic [XLEN-1:0] operand;
    logic [XLEN-1:0] alu_new;
    logic            write_needed;
    logic            read_only;
    logic            unused_opcode;

    // The pipeline only presents SYSTEM-opcode instructions, so the opcode bits are not decoded.
    assign unused_opcode = ^instr[6:0];

    assign operand = funct3_q[2] ? zimm_q : rs1_data_q;
    // The zimm field and the rs1 index occupy the same bits, so one test covers both forms.
    assign write_needed = funct3_is_rw(funct3_q) || (rs1_idx_q != 5'd0);
    assign read_only    = (addr_q[11:10] == 2'b11);

    csr_alu #(.XLEN(XLEN)) u_alu (
        .funct3  (funct3_q),
        .old_val (csr_rd),
        .operand (operand),
        .new_val (alu_new)
    );

    always_comb begin
        next_state   = state;
        req_ready    = 1'b0;
        busy         = 1'b1;
        csr_addr     = '0;
        csr_we       = 1'b0;
        csr_wd       = '0;
        resp_valid   = 1'b0;
        resp_data    = old_q;
        resp_rd_addr = rd_q;
        resp_illegal = illegal_q;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    next_state = funct3_illegal(instr[14:12]) ? RESP : READ;
                end
            end
            READ: begin
                csr_addr = addr_q;
                if (write_needed && !read_only) begin
                    next_state = WRITE;
                end else begin
                    next_state = RESP;
                end
            end
            WRITE: begin
                csr_addr   = addr_q;
                // A reset in this cycle aborts the request before the CSR file sees the edge.
                csr_we     = !rst;
                csr_wd     = new_q;
                next_state = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            funct3_q   <= '0;
            rd_q       <= '0;
            rs1_idx_q  <= '0;
            rs1_data_q <= '0;
            zimm_q     <= '0;
            old_q      <= '0;
            new_q      <= '0;
            illegal_q  <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q     <= instr[31:20];
                        funct3_q   <= instr[14:12];
                        rd_q       <= instr[11:7];
                        rs1_idx_q  <= instr[19:15];
                        rs1_data_q <= rs1_data;
                        zimm_q     <= {{(XLEN-5){1'b0}}, instr[19:15]};
                        old_q      <= '0;
                        new_q      <= '0;
                        illegal_q  <= funct3_illegal(instr[14:12]);
                    end
                end
                READ: begin
                    if (write_needed && read_only) begin
                        illegal_q <= 1'b1;
                        old_q     <= '0;
                    end else begin
                        old_q <= csr_rd;
                        new_q <= alu_new;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        illegal_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Directed bench for csr_access_ctrl: a behavioural CSR file, a scoreboard of
// expected responses and per-request latency / write-pulse checks.
module tb_csr_access_ctrl;
    import csr_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [31:0]     instr = '0;
    logic [XLEN-1:0] rs1_data = '0;
    logic [11:0]     csr_addr;
    logic            csr_we;
    logic [XLEN-1:0] csr_wd;
    logic [XLEN-1:0] csr_rd;
    logic            resp_valid;
    logic            resp_ready = 1'b0;
    logic [4:0]      resp_rd_addr;
    logic [XLEN-1:0] resp_data;
    logic            resp_illegal;
    logic            busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        illegal;
        int          n_we;
        logic [31:0] wd;
        int          lat;
    } exp_t;

    exp_t sb[$];

    logic [31:0] csr_mem [0:4095];
    int          we_count = 0;
    logic [31:0] last_wd = '0;
    logic [11:0] last_waddr = '0;

    always #5 clk = ~clk;

    csr_access_ctrl #(.XLEN(XLEN)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .instr        (instr),
        .rs1_data     (rs1_data),
        .csr_addr     (csr_addr),
        .csr_we       (csr_we),
        .csr_wd       (csr_wd),
        .csr_rd       (csr_rd),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rd_addr (resp_rd_addr),
        .resp_data    (resp_data),
        .resp_illegal (resp_illegal),
        .busy         (busy)
    );

    assign csr_rd = csr_mem[csr_addr];

    always @(posedge clk) begin
        if (csr_we) begin
            we_count   = we_count + 1;
            last_wd    = csr_wd;
            last_waddr = csr_addr;
            csr_mem[csr_addr] = csr_wd;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [11:0] addr);
        return {addr, rs1, f3, rd, SYSTEM_OPCODE};
    endfunction

    task automatic do_req(input string tag, input logic [31:0] ins, input logic [31:0] rs1v,
                          input logic [31:0] e_data, input logic [4:0] e_rd, input logic e_ill,
                          input int e_nwe, input logic [31:0] e_wd, input int e_lat, input int hold);
        exp_t e;
        exp_t got;
        int   lat;
        int   we_before;
        e.rd = e_rd; e.data = e_data; e.illegal = e_ill; e.n_we = e_nwe; e.wd = e_wd; e.lat = e_lat;
        @(negedge clk);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        instr     = ins;
        rs1_data  = rs1v;
        we_before = we_count;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_timeout"}, 32'(lat < 10), 32'd1);
        got = sb.pop_front();
        check({tag, "_latency"}, 32'(lat), 32'(got.lat));
        check({tag, "_rd"}, 32'(resp_rd_addr), 32'(got.rd));
        check({tag, "_data"}, resp_data, got.data);
        check({tag, "_illegal"}, 32'(resp_illegal), 32'(got.illegal));
        check({tag, "_we_pulses"}, 32'(we_count - we_before), 32'(got.n_we));
        if (got.n_we != 0) begin
            check({tag, "_wd"}, last_wd, got.wd);
            check({tag, "_waddr"}, 32'(last_waddr), 32'(ins[31:20]));
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
            check({tag, "_hold_data"}, resp_data, got.data);
            check({tag, "_hold_rd"}, 32'(resp_rd_addr), 32'(got.rd));
            check({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check({tag, "_done_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "_done_req_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int we_snap;
        for (int i = 0; i < 4096; i++) csr_mem[i] = '0;
        csr_mem[12'h001] = 32'h5;
        csr_mem[12'h300] = 32'hA;
        csr_mem[12'h340] = 32'h1234_5678;
        csr_mem[12'hC00] = 32'h1234;
        csr_mem[12'h005] = 32'h77;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_illegal", 32'(resp_illegal), 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_csr_we", 32'(csr_we), 32'd0);
        check("rst_csr_addr", 32'(csr_addr), 32'd0);
        check("rst_csr_wd", csr_wd, 32'd0);
        rst = 1'b0;

        do_req("csrrw", mk(CSRRW, 5'd1, 5'd1, 12'h001), 32'd3, 32'h5, 5'd1, 1'b0, 1, 32'h3, 3, 0);
        check("csrrw_mem", csr_mem[12'h001], 32'h3);

        do_req("csrrs_x0", mk(CSRRS, 5'd2, 5'd0, 12'h300), 32'hFFFF, 32'hA, 5'd2, 1'b0, 0, 32'h0, 2, 0);
        check("csrrs_x0_mem", csr_mem[12'h300], 32'hA);

        @(negedge clk);
        csr_mem[12'h300] = 32'hF;
        do_req("csrrci", mk(CSRRCI, 5'd3, 5'd3, 12'h300), 32'hDEAD, 32'hF, 5'd3, 1'b0, 1, 32'hC, 3, 0);
        do_req("csrrsi", mk(CSRRSI, 5'd4, 5'h10, 12'h300), 32'h0, 32'hC, 5'd4, 1'b0, 1, 32'h1C, 3, 0);
        do_req("csrrwi", mk(CSRRWI, 5'd5, 5'h1F, 12'h340), 32'hFFFF_FFFF, 32'h1234_5678, 5'd5, 1'b0, 1, 32'h1F, 3, 0);

        do_req("ro_write", mk(CSRRW, 5'd6, 5'd5, 12'hC00), 32'h55, 32'h0, 5'd6, 1'b1, 0, 32'h0, 2, 0);
        check("ro_write_mem", csr_mem[12'hC00], 32'h1234);
        do_req("f3_100", mk(3'b100, 5'd7, 5'd1, 12'h001), 32'h9, 32'h0, 5'd7, 1'b1, 0, 32'h0, 1, 0);
        do_req("ro_read", mk(CSRRS, 5'd8, 5'd0, 12'hC00), 32'h1, 32'h1234, 5'd8, 1'b0, 0, 32'h0, 2, 0);

        do_req("hold", mk(CSRRC, 5'd9, 5'd2, 12'h001), 32'h1, 32'h3, 5'd9, 1'b0, 1, 32'h2, 3, 4);

        @(negedge clk);
        we_snap   = we_count;
        req_valid = 1'b1;
        instr     = mk(CSRRW, 5'd10, 5'd3, 12'h005);
        rs1_data  = 32'h99;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_busy_in_read", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd1);
        check("abort_resp_valid", 32'(resp_valid), 32'd0);
        repeat (3) @(negedge clk);
        check("abort_no_we", 32'(we_count - we_snap), 32'd0);
        check("abort_mem", csr_mem[12'h005], 32'h77);

        do_req("after_abort", mk(CSRRW, 5'd10, 5'd3, 12'h005), 32'h99, 32'h77, 5'd10, 1'b0, 1, 32'h99, 3, 0);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/csr_access_ctrl.md
CSR_ACCESS_CTRL -- requirements
Module: csr_access_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- XLEN, 32, data width of CSRs and rs1 operand.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on rising edge.
- rst, in, 1, synchronous active-high reset.
- req_valid, in, 1, pipeline presents a SYSTEM-opcode CSR instruction.
- req_ready, out, 1, controller can accept a request.
- instr, in, 32, full instruction word.
- rs1_data, in, XLEN, rs1 register value.
- csr_addr, out, 12, CSR file address.
- csr_we, out, 1, CSR file write enable.
- csr_wd, out, XLEN, CSR file write data.
- csr_rd, in, XLEN, CSR file combinational read data for csr_addr.
- resp_valid, out, 1, result available.
- resp_ready, in, 1, writeback accepts result.
- resp_rd_addr, out, 5, destination register index (instr[11:7]).
- resp_data, out, XLEN, old CSR value.
- resp_illegal, out, 1, instruction is illegal and was not executed.
- busy, out, 1, high in any state other than IDLE.
REQ-003 The block has one clock domain; reset is synchronous and active-high.

Function
REQ-004 The FSM SHALL have four states: IDLE, READ, WRITE and RESP.
REQ-005 IDLE: req_ready=1; on req_valid, latch the request, then go to RESP with illegal=1 if funct3 is 000 or 100, otherwise go to READ.
- Latched fields: instr[31:20] as address, funct3, rd, rs1 index, rs1_data, zimm (zero-extended instr[19:15]).
REQ-006 READ: csr_addr=latched address; capture csr_rd into old-value register; compute new value.
- new value = operand for RW; old|operand for RS; old&~operand for RC.
- Operand = rs1_data for funct3[2]=0, zimm for funct3[2]=1.
REQ-007 A write is needed for RW/RWI always, and for RS/RC/RSI/RCI only if the rs1 field/zimm is nonzero.
REQ-008 READ then goes to WRITE if a write is needed, otherwise to RESP.
- Exception: write needed and address[11:10]==2'b11 (read-only CSR) -> RESP with illegal=1 and no write.
REQ-009 WRITE SHALL assert csr_we=1 for exactly one cycle with csr_wd=new value and csr_addr held, then go to RESP.
REQ-010 RESP: resp_valid=1 with resp_data=old value, resp_rd_addr and resp_illegal all stable until resp_ready; on resp_valid&resp_ready return to IDLE.
REQ-011 Latency from accept edge to resp_valid SHALL be 3 cycles with write, 2 cycles without write, and 1 cycle for a funct3 illegal.
REQ-012 On illegal, resp_data SHALL be 0 and csr_we SHALL never assert for that request.
REQ-013 req_ready SHALL be 0 outside IDLE, so no new request is accepted in the cycle resp_valid&resp_ready completes.
REQ-014 csr_we SHALL be 0 in every state except WRITE; csr_addr and csr_wd SHALL be 0 in IDLE.
REQ-015 Arithmetic is bitwise at XLEN; zimm is zero-extended with no sign extension.

Reset
REQ-016 While rst=1, at the next edge: state=IDLE; resp_valid, resp_illegal and csr_we go to 0; latched registers and resp_data go to 0; req_ready=1 after reset.
REQ-017 rst asserted in READ or WRITE SHALL abort the request; no csr_we pulse occurs on or after the reset edge.

Structure
REQ-018 csr_pkg SHALL hold the funct3 enum (CSRRW=001, CSRRS=010, CSRRC=011, CSRRWI=101, CSRRSI=110, CSRRCI=111), the state enum, and the SYSTEM opcode 7'b1110011.
REQ-019 The new-value computation SHALL be one combinational sub-module csr_alu (inputs: funct3, old, operand; output: new).

Verification
REQ-020 CSRRW x1, 0x001, x1 with rs1_data=3 and CSR 0x001 holding 0x5 -> one csr_we pulse with wd=3; resp_data=5, rd=1, 3 cycles after accept.
REQ-021 CSRRS with rs1=x0 on CSR 0x300=0xA -> no csr_we; resp_data=0xA after 2 cycles.
REQ-022 CSRRCI zimm=0x3 on 0x300=0xF -> wd=0xC; then CSRRSI zimm=0x10 -> wd=0x1C.
REQ-023 CSRRW to address 0xC00 -> resp_illegal=1, resp_data=0, no csr_we; funct3=100 -> illegal after 1 cycle.
REQ-024 Hold resp_ready=0 for 4 cycles -> resp outputs stable and req_ready=0 throughout; accept completes on the first resp_ready cycle.
REQ-025 Assert rst in the READ cycle of a CSRRW -> no csr_we pulse, IDLE next cycle, CSR value unchanged.
